// File: rtl/rgb_seq_pkg.sv
// Shared encodings for the RGB fade sequencer: FSM states, cfg_data layout and defaults.
package rgb_seq_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFade = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  // Field positions inside a table entry, counted in PWM_BITS-wide slots (red in the MSBs).
  localparam int unsigned RED_LSB  = 3;
  localparam int unsigned GRN_LSB  = 2;
  localparam int unsigned BLU_LSB  = 1;
  localparam int unsigned HOLD_LSB = 0;

  localparam int unsigned TICK_DIV_DEFAULT = 12000;

  // Slot of colour channel 0=red, 1=green, 2=blue.
  function automatic int unsigned chan_lsb(input int unsigned chan);
    case (chan)
      0:       return RED_LSB;
      1:       return GRN_LSB;
      default: return BLU_LSB;
    endcase
  endfunction

endpackage

// File: rtl/rgb_fade_sequencer_if.sv
// Colour-table configuration bus of the fade sequencer.
interface rgb_fade_sequencer_if #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEPS    = 4
);

  logic                        cfg_we;
  logic [$clog2(STEPS)-1:0]    cfg_addr;
  logic [4*PWM_BITS-1:0]       cfg_data;

  modport master (output cfg_we, output cfg_addr, output cfg_data);
  modport slave  (input  cfg_we, input  cfg_addr, input  cfg_data);

endinterface

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: duty shadow reloaded only at the counter wrap, plus registered comparator.
module rgb_pwm_channel #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                hw_clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm
);

  logic [PWM_BITS-1:0] shadow_q;
  logic                pwm_q;

  always_ff @(posedge hw_clk) begin
    if (rst) begin
      shadow_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      if (wrap) begin
        shadow_q <= duty;
      end
      pwm_q <= (pwm_cnt < shadow_q);
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Colour-table driven RGB fader feeding SB_RGBA_DRV: linear fade to each step, hold, advance.
module rgb_fade_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEPS    = 4,
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic                     hw_clk,
  input  logic                     rst,
  input  logic                     enable,
  rgb_fade_sequencer_if.slave      cfg,
  output logic                     pwm_red,
  output logic                     pwm_green,
  output logic                     pwm_blue,
  output logic                     led_en,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     busy
);

  localparam int unsigned AddrW  = $clog2(STEPS);
  localparam int unsigned EntryW = 4 * PWM_BITS;
  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef logic [PWM_BITS-1:0] duty_t;

  logic [EntryW-1:0] tbl_q [STEPS];
  logic [EntryW-1:0] tgt_q, tgt_d;
  duty_t             cur_q [3];
  duty_t             cur_d [3];
  duty_t             hold_q, hold_d;
  logic [1:0]        state_q, state_d;
  logic [AddrW-1:0]  step_q, step_d;
  logic [PrescW-1:0] presc_q;
  duty_t             pwm_cnt_q;
  logic              busy_q;
  logic              tick;
  logic              wrap;
  logic              at_target;

  function automatic duty_t entry_field(input logic [EntryW-1:0] entry, input int unsigned slot);
    return entry[slot*PWM_BITS +: PWM_BITS];
  endfunction

  // Unsigned compare then +/-1, so a channel can never overshoot or wrap.
  function automatic duty_t step_toward(input duty_t cur, input duty_t tgt);
    if (cur < tgt) return cur + duty_t'(1);
    if (cur > tgt) return cur - duty_t'(1);
    return cur;
  endfunction

  assign tick = (state_q != StIdle) && (presc_q == PrescW'(TICK_DIV - 1));
  assign wrap = &pwm_cnt_q;

  always_comb begin
    at_target = 1'b1;
    for (int unsigned c = 0; c < 3; c++) begin
      if (cur_q[c] != entry_field(tgt_q, chan_lsb(c))) begin
        at_target = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tgt_d   = tgt_q;
    hold_d  = hold_q;
    for (int unsigned c = 0; c < 3; c++) begin
      cur_d[c] = cur_q[c];
    end

    if (!enable) begin
      state_d = StIdle;
      step_d  = '0;
      hold_d  = '0;
      for (int unsigned c = 0; c < 3; c++) begin
        cur_d[c] = '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          tgt_d   = tbl_q[0];
          state_d = StFade;
        end
        StFade: begin
          if (at_target) begin
            state_d = StHold;
            hold_d  = entry_field(tgt_q, HOLD_LSB);
          end else if (tick) begin
            for (int unsigned c = 0; c < 3; c++) begin
              cur_d[c] = step_toward(cur_q[c], entry_field(tgt_q, chan_lsb(c)));
            end
          end
        end
        StHold: begin
          if (tick) begin
            if (hold_q == '0) begin
              step_d  = step_q + AddrW'(1);
              // Reads the pre-write table, so a same-edge cfg write lands next lap.
              tgt_d   = tbl_q[step_q + AddrW'(1)];
              state_d = StFade;
            end else begin
              hold_d = hold_q - duty_t'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge hw_clk) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) begin
        tbl_q[i] <= '0;
      end
      for (int unsigned c = 0; c < 3; c++) begin
        cur_q[c] <= '0;
      end
      tgt_q     <= '0;
      hold_q    <= '0;
      state_q   <= StIdle;
      step_q    <= '0;
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      if (cfg.cfg_we) begin
        tbl_q[cfg.cfg_addr] <= cfg.cfg_data;
      end
      for (int unsigned c = 0; c < 3; c++) begin
        cur_q[c] <= cur_d[c];
      end
      tgt_q     <= tgt_d;
      hold_q    <= hold_d;
      state_q   <= state_d;
      step_q    <= step_d;
      pwm_cnt_q <= pwm_cnt_q + duty_t'(1);
      busy_q    <= (state_d != StIdle);
      if ((state_q == StIdle) || !enable || tick) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + PrescW'(1);
      end
    end
  end

  rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_red (
    .hw_clk  (hw_clk),
    .rst     (rst),
    .pwm_cnt (pwm_cnt_q),
    .wrap    (wrap),
    .duty    (cur_q[0]),
    .pwm     (pwm_red)
  );

  rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_green (
    .hw_clk  (hw_clk),
    .rst     (rst),
    .pwm_cnt (pwm_cnt_q),
    .wrap    (wrap),
    .duty    (cur_q[1]),
    .pwm     (pwm_green)
  );

  rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_blue (
    .hw_clk  (hw_clk),
    .rst     (rst),
    .pwm_cnt (pwm_cnt_q),
    .wrap    (wrap),
    .duty    (cur_q[2]),
    .pwm     (pwm_blue)
  );

  assign led_en   = busy_q;
  assign busy     = busy_q;
  assign step_idx = step_q;

endmodule
